status_event_capture: RTL and testbench



---
 rtl/status_event_capture.sv | 103 ++++++++++
 tb/tb_status_event_capture.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/status_event_capture.sv
// Synchronizes, glitch-filters and edge-qualifies up to eight raw status inputs,
// then holds each event in a sticky flag that drives the status register.
module status_event_capture #(
  parameter int         NumInputs = 8,
  parameter int         FilterLen = 2,
  parameter logic [7:0] RiseMask  = 8'hFF,
  parameter logic [7:0] FallMask  = 8'h00,
  parameter logic [7:0] IntMask   = 8'hFF,
  parameter bit         Sticky    = 1'b1
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] raw_bus,
  input  logic [7:0] clear_bus,
  output logic [7:0] status_bus,
  output logic [7:0] ovf_bus,
  output logic [7:0] level_bus,
  output logic       intr
);

  localparam logic [3:0] FiltLen = 4'(FilterLen);

  logic [7:0] w_flag;
  logic [7:0] w_ovf;
  logic [7:0] w_level;
  logic       w_unused;

  // Inactive bits and ignored clears still arrive on the ports.
  assign w_unused = ^{raw_bus, clear_bus};

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_bit
      if (gi < NumInputs) begin : g_active
        logic       r_s1;
        logic       r_s2;
        logic       r_filt;
        logic [3:0] r_cnt;
        logic       r_flag;
        logic       r_ovf;
        logic       w_diff;
        logic       w_update;
        logic       w_event;

        assign w_diff   = r_s2 ^ r_filt;
        assign w_update = w_diff && (r_cnt == FiltLen);
        assign w_event  = w_update && (r_s2 ? RiseMask[gi] : FallMask[gi]);

        always_ff @(posedge clock or negedge reset_n) begin
          if (!reset_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
          end else begin
            r_s1 <= raw_bus[gi];
            r_s2 <= r_s1;
          end
        end

        // The counter only runs while the synchronized level disagrees with filt.
        always_ff @(posedge clock or negedge reset_n) begin
          if (!reset_n) begin
            r_filt <= 1'b0;
            r_cnt  <= 4'd0;
          end else if (!w_diff) begin
            r_cnt <= 4'd0;
          end else if (w_update) begin
            r_filt <= r_s2;
            r_cnt  <= 4'd0;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end

        always_ff @(posedge clock or negedge reset_n) begin
          if (!reset_n) begin
            r_flag <= 1'b0;
            r_ovf  <= 1'b0;
          end else if (Sticky) begin
            r_flag <= w_event | (r_flag & ~clear_bus[gi]);
            r_ovf  <= (w_event & r_flag & ~clear_bus[gi]) | (r_ovf & ~clear_bus[gi]);
          end else begin
            r_flag <= w_event;
            r_ovf  <= 1'b0;
          end
        end

        assign w_flag[gi]  = r_flag;
        assign w_ovf[gi]   = r_ovf;
        assign w_level[gi] = r_filt;
      end else begin : g_idle
        assign w_flag[gi]  = 1'b0;
        assign w_ovf[gi]   = 1'b0;
        assign w_level[gi] = 1'b0;
      end
    end
  endgenerate

  assign status_bus = w_flag;
  assign ovf_bus    = w_ovf;
  assign level_bus  = w_level;
  assign intr       = |(w_flag & IntMask);

endmodule

// File: tb/tb_status_event_capture.sv
// Directed bench: four parameterizations of status_event_capture driven side by side.
module tb_status_event_capture;

  logic       clock;
  logic       reset_n;
  logic [7:0] raw_a, raw_b, raw_c, raw_d;
  logic [7:0] clr_a, clr_b, clr_c, clr_d;
  logic [7:0] st_a, st_b, st_c, st_d;
  logic [7:0] ov_a, ov_b, ov_c, ov_d;
  logic [7:0] lv_a, lv_b, lv_c, lv_d;
  logic       in_a, in_b, in_c, in_d;

  int n_vec = 0;
  int n_err = 0;

  // Defaults: FilterLen=2, rise-only, all bits interrupt, sticky.
  status_event_capture u_dut_a (
    .clock(clock), .reset_n(reset_n), .raw_bus(raw_a), .clear_bus(clr_a),
    .status_bus(st_a), .ovf_bus(ov_a), .level_bus(lv_a), .intr(in_a));

  // Bit 0 events on both edges.
  status_event_capture #(.RiseMask(8'h01), .FallMask(8'h01)) u_dut_b (
    .clock(clock), .reset_n(reset_n), .raw_bus(raw_b), .clear_bus(clr_b),
    .status_bus(st_b), .ovf_bus(ov_b), .level_bus(lv_b), .intr(in_b));

  // Pulse mode with only four active bits.
  status_event_capture #(.NumInputs(4), .Sticky(1'b0)) u_dut_c (
    .clock(clock), .reset_n(reset_n), .raw_bus(raw_c), .clear_bus(clr_c),
    .status_bus(st_c), .ovf_bus(ov_c), .level_bus(lv_c), .intr(in_c));

  // No filtering, low nibble interrupts only.
  status_event_capture #(.FilterLen(0), .IntMask(8'h0F)) u_dut_d (
    .clock(clock), .reset_n(reset_n), .raw_bus(raw_d), .clear_bus(clr_d),
    .status_bus(st_d), .ovf_bus(ov_d), .level_bus(lv_d), .intr(in_d));

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    raw_a = 8'hA5; raw_b = 8'h00; raw_c = 8'hFF; raw_d = 8'h00;
    clr_a = 8'h00; clr_b = 8'h00; clr_c = 8'h00; clr_d = 8'h00;
    repeat (4) step();
    chk("rst_status_a", st_a, 8'h00);
    chk("rst_level_a", lv_a, 8'h00);
    chk("rst_ovf_a", ov_a, 8'h00);
    chk("rst_intr_a", {7'd0, in_a}, 8'h00);
    chk("rst_status_c", st_c, 8'h00);

    // Release: the next rising edge is E0; flags land at E4.
    reset_n = 1'b1;
    repeat (4) step();
    chk("rel_e3_status_a", st_a, 8'h00);
    chk("rel_e3_status_c", st_c, 8'h00);
    step();
    chk("rel_e4_status_a", st_a, 8'hA5);
    chk("rel_e4_level_a", lv_a, 8'hA5);
    chk("rel_e4_intr_a", {7'd0, in_a}, 8'h01);
    chk("pulse_e4_status_c", st_c, 8'h0F);
    chk("pulse_e4_level_c", lv_c, 8'h0F);
    chk("pulse_e4_intr_c", {7'd0, in_c}, 8'h01);
    chk("pulse_e4_ovf_c", ov_c, 8'h00);
    chk("idle_status_d", st_d, 8'h00);
    step();
    chk("pulse_e5_status_c", st_c, 8'h00);
    chk("sticky_e5_status_a", st_a, 8'hA5);

    // Two-sample glitch on bit 3 is rejected.
    raw_a = 8'hAD;
    repeat (2) step();
    raw_a = 8'hA5;
    repeat (6) step();
    chk("glitch_status_a", st_a, 8'hA5);
    chk("glitch_level_a", lv_a, 8'hA5);

    // Three-sample pulse on bit 3 passes, landing exactly at E4.
    raw_a = 8'hAD;
    repeat (3) step();
    raw_a = 8'hA5;
    step();
    chk("hold3_e3_status_a", st_a, 8'hA5);
    step();
    chk("hold3_e4_status_a", st_a, 8'hAD);
    repeat (6) step();
    chk("hold3_after_status_a", st_a, 8'hAD);
    chk("hold3_after_level_a", lv_a, 8'hA5);
    chk("hold3_ovf_a", ov_a, 8'h00);

    clr_a = 8'hFF;
    step();
    clr_a = 8'h00;
    chk("clrall_status_a", st_a, 8'h00);
    chk("clrall_intr_a", {7'd0, in_a}, 8'h00);

    // Masked falling edge on bit 5 raises no flag.
    raw_a = 8'h85;
    repeat (6) step();
    chk("fall_level_a", lv_a, 8'h85);
    chk("fall_status_a", st_a, 8'h00);

    // Clear strobe coincides with the bit-5 rising event: set wins.
    raw_a = 8'hA5;
    repeat (4) step();
    chk("coll_e3_status_a", st_a, 8'h00);
    clr_a = 8'h20;
    step();
    clr_a = 8'h00;
    chk("coll_status_a", st_a, 8'h20);
    chk("coll_ovf_a", ov_a, 8'h00);

    // Both-edge masks on bit 0: second event overflows.
    raw_b = 8'h01;
    repeat (4) step();
    chk("edge_e3_status_b", st_b, 8'h00);
    step();
    chk("edge_rise_status_b", st_b, 8'h01);
    chk("edge_rise_intr_b", {7'd0, in_b}, 8'h01);
    repeat (3) step();
    raw_b = 8'h00;
    repeat (4) step();
    chk("edge_e3_ovf_b", ov_b, 8'h00);
    step();
    chk("edge_fall_ovf_b", ov_b, 8'h01);
    chk("edge_fall_status_b", st_b, 8'h01);
    chk("edge_fall_level_b", lv_b, 8'h00);
    clr_b = 8'h01;
    step();
    clr_b = 8'h00;
    chk("edge_clr_status_b", st_b, 8'h00);
    chk("edge_clr_ovf_b", ov_b, 8'h00);
    chk("edge_clr_intr_b", {7'd0, in_b}, 8'h00);

    // FilterLen=0: flag at E2; bit 6 masked off intr, bit 1 not.
    raw_d = 8'h40;
    repeat (2) step();
    chk("fl0_e1_status_d", st_d, 8'h00);
    step();
    chk("fl0_e2_status_d", st_d, 8'h40);
    chk("imask_b6_intr_d", {7'd0, in_d}, 8'h00);
    raw_d = 8'h42;
    repeat (3) step();
    chk("imask_b1_status_d", st_d, 8'h42);
    chk("imask_b1_intr_d", {7'd0, in_d}, 8'h01);

    chk("pulse_end_status_c", st_c, 8'h00);
    chk("pulse_end_ovf_c", ov_c, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
